// File: rtl/handshake_pkg.sv
// handshake_pkg
// Shared constants and width helpers for the handshake dataflow fabric.
package handshake_pkg;

    localparam int HS_DEFAULT_DATA_WIDTH = 32;
    localparam int HS_MAX_SLOTS          = 64;

    // Ceiling log2. Used for counter and pointer widths so that depths
    // that are not powers of two still get enough bits.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return width;
    endfunction

    // Pointer width for a storage of the given depth. A single-slot
    // storage still needs a 1-bit pointer so the port is never zero-width.
    function automatic int ptrWidth(input int slots);
        return (slots > 1) ? clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/handshake_elastic_fifo_if.sv
// handshake_elastic_fifo_if
// Input and output valid/ready channels of the elastic FIFO bundled together.
// The slave modport is the FIFO's view; the master modport is the view of
// whatever sits around it (producer on ins, consumer on outs).
interface handshake_elastic_fifo_if
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = HS_DEFAULT_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins,
        output ins_valid,
        input  ins_ready,
        input  outs,
        input  outs_valid,
        output outs_ready
    );

    modport slave (
        input  ins,
        input  ins_valid,
        output ins_ready,
        output outs,
        output outs_valid,
        input  outs_ready
    );

endinterface

// File: rtl/handshake_fifo_ram.sv
// handshake_fifo_ram
// NUM_SLOTS x DATA_WIDTH token storage: one synchronous write port and one
// asynchronous read port. Contents are deliberately never reset.
module handshake_fifo_ram
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = HS_DEFAULT_DATA_WIDTH,
    parameter int NUM_SLOTS  = 4,
    localparam int PTR_W     = ptrWidth(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [PTR_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];

    // Write the incoming token into its slot on an accepted push.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// handshake_elastic_fifo
// Elastic valid/ready FIFO that decouples a producer from its consumer and
// cuts the combinational ready path between them.
// Optional feature: define HANDSHAKE_FIFO_BYPASS_EN to forward the input
// straight to the output while the FIFO is empty (zero-latency pass-through,
// at the cost of an ins_valid -> outs_valid combinational path).
module handshake_elastic_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = HS_DEFAULT_DATA_WIDTH,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    handshake_elastic_fifo_if.slave hs
);

    localparam int CNT_W = clog2(NUM_SLOTS + 1);
    localparam int PTR_W = ptrWidth(NUM_SLOTS);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_SLOTS);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(NUM_SLOTS - 1);

    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_empty;
    logic                  w_insReady;
    logic                  w_outsValid;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_ramData;
    logic [DATA_WIDTH-1:0] w_outsData;

    // Explicit wrap compare so depths that are not powers of two work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Both handshake flags are held low while rst is asserted, which also
    // guarantees a handshake on the reset edge never counts.
    assign w_empty    = (r_count == '0);
    assign w_insReady = rst && (r_count != FULL_COUNT);

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    assign w_outsValid = rst && (!w_empty || hs.ins_valid);
    assign w_outsData  = w_empty ? hs.ins : w_ramData;
    assign w_bypass    = w_empty && hs.ins_valid && hs.outs_ready;
`else
    assign w_outsValid = rst && !w_empty;
    assign w_outsData  = w_ramData;
    assign w_bypass    = 1'b0;
`endif

    // A token that passes straight through is neither stored nor retired.
    assign w_push = hs.ins_valid && w_insReady && !w_bypass;
    assign w_pop  = w_outsValid && hs.outs_ready && !w_bypass;

    assign hs.ins_ready  = w_insReady;
    assign hs.outs_valid = w_outsValid;
    assign hs.outs       = w_outsValid ? w_outsData : '0;

    handshake_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wrPtr),
        .i_wdata (hs.ins),
        .i_raddr (r_rdPtr),
        .o_rdata (w_ramData)
    );

    // Advance pointers on push/pop and keep occupancy in step with them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// tb_handshake_elastic_fifo
// Directed scenarios followed by random traffic, all compared each cycle
// against a queue-based model of the FIFO. Follows HANDSHAKE_FIFO_BYPASS_EN
// when the design is built with it.
module tb_handshake_elastic_fifo;

    localparam int DW = 12;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    logic [DW-1:0] modelQ [$];

    handshake_elastic_fifo_if #(.DATA_WIDTH(DW)) hsIf ();

    handshake_elastic_fifo #(
        .DATA_WIDTH (DW),
        .NUM_SLOTS  (NS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hs  (hsIf)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle against the
    // model, then apply the handshakes of the edge to the model.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [DW-1:0] d, input logic o);
        logic          expReady;
        logic          expValid;
        logic [DW-1:0] expOuts;
        logic          push;
        logic          pop;

        rst             = r;
        hsIf.ins_valid  = v;
        hsIf.ins        = d;
        hsIf.outs_ready = o;

        @(negedge clk);
        expReady = r && (modelQ.size() < NS);
        if (modelQ.size() > 0) begin
            expValid = r;
            expOuts  = r ? modelQ[0] : '0;
        end else begin
`ifdef HANDSHAKE_FIFO_BYPASS_EN
            expValid = r && v;
            expOuts  = (r && v) ? d : '0;
`else
            expValid = 1'b0;
            expOuts  = '0;
`endif
        end
        checkOutput("ins_ready",  32'(hsIf.ins_ready),  32'(expReady));
        checkOutput("outs_valid", 32'(hsIf.outs_valid), 32'(expValid));
        checkOutput("outs",       32'(hsIf.outs),       32'(expOuts));
        checkOutput("count",      32'(dut.r_count),     32'(modelQ.size()));

        @(posedge clk);
        push = v && expReady;
        pop  = expValid && o;
        if (!r) begin
            modelQ.delete();
        end else if (modelQ.size() == 0 && push && pop) begin
            // token passed straight through, nothing stored
        end else begin
            if (pop) begin
                void'(modelQ.pop_front());
            end
            if (push) begin
                modelQ.push_back(d);
            end
        end
        #1;
    endtask

    // Scenario sequence followed by randomized traffic and the summary.
    initial begin
        hsIf.ins        = '0;
        hsIf.ins_valid  = 1'b0;
        hsIf.outs_ready = 1'b0;

        repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Fill with a blocked consumer, keep offering a fifth token.
        repeat (6) applyStimulus(1'b1, 1'b1, 12'hF0B, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        // Drain order.
        applyStimulus(1'b1, 1'b1, 12'h001, 1'b0);
        applyStimulus(1'b1, 1'b1, 12'h002, 1'b0);
        applyStimulus(1'b1, 1'b1, 12'h003, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        // Sustained streaming through wrapping pointers.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, DW'(12'h100 + i), 1'b1);
        end
        repeat (2) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        // Full, then simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, DW'(12'h200 + i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, DW'(12'h300 + i), 1'b1);
        end
        repeat (6) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        // Mid-stream reset at occupancy two.
        applyStimulus(1'b1, 1'b1, 12'hAAA, 1'b0);
        applyStimulus(1'b1, 1'b1, 12'hBBB, 1'b0);
        applyStimulus(1'b0, 1'b1, 12'hDDD, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b1, 12'hCCC, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        // Random traffic: a slow consumer first, then a balanced one.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 59) != 0,
                          $urandom_range(0, 1) == 1,
                          DW'($urandom),
                          (i < 200) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 1) == 1));
        end
        repeat (6) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
